// File: rtl/vga_pkg.sv
// Shared constants and read-FSM encoding for the VGA pixel path.
package vga_pkg;
  localparam int PIX_W        = 16;
  localparam int H_ACTIVE     = 1024;
  localparam int V_ACTIVE     = 768;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } rd_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; dout is registered on pop and reads 0 otherwise.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      dout <= pop_ok ? mem[rd_ptr[AW-1:0]] : '0;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/vga_frame_reader.sv
// Burst-fetches the frame from memory into a FIFO and serves one pixel per data_req.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int DATA_W       = PIX_W,
  parameter int ADDR_W       = 20,
  parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS,
  parameter int BASE_ADDR    = 0,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_sync,
  input  logic                          data_req,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  input  logic                          mem_rvalid,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int IW = $clog2(FRAME_PIXELS + 1);
  localparam int OW = $clog2(BURST_LEN + 1);
  localparam logic [IW-1:0]     FRAME_I = IW'(FRAME_PIXELS);
  localparam logic [IW-1:0]     BURST_I = IW'(BURST_LEN);
  localparam logic [OW-1:0]     BURST_O = OW'(BURST_LEN);
  localparam logic [OW-1:0]     OUT_ONE = OW'(1);
  localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);

  rd_state_t     state;
  logic          fs_d;
  logic          flush_pend;
  logic [IW-1:0] issued;
  logic [OW-1:0] outstanding;
  logic          fs_rise;
  logic          dropping;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_clear;
  logic          fifo_empty;
  logic          fifo_full;
  logic          more;
  logic          room;

  assign fs_rise    = frame_sync & ~fs_d;
  // Beats still arriving for the old frame are discarded from the edge cycle on.
  assign dropping   = flush_pend | fs_rise;
  assign fifo_push  = (state == ST_WAIT) && mem_rvalid && !dropping && !fifo_full;
  assign fifo_pop   = data_req && !fifo_empty && (state != ST_FLUSH);
  assign fifo_clear = (state == ST_FLUSH);
  assign more       = (issued < FRAME_I);
  assign room       = (32'(fifo_level) + 32'(outstanding) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (fifo_clear),
    .din   (mem_rdata),
    .dout  (pix_data),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fs_d        <= 1'b0;
      flush_pend  <= 1'b0;
      underflow   <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= BASE_A;
      issued      <= '0;
      outstanding <= '0;
    end else begin
      fs_d <= frame_sync;
      if (fs_rise) begin
        flush_pend <= 1'b1;
        underflow  <= 1'b0;
      end
      if (data_req && (fifo_empty || state == ST_FLUSH)) underflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (flush_pend || fs_rise) begin
            state <= ST_FLUSH;
          end else if (more && room) begin
            state   <= ST_REQ;
            mem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state       <= ST_WAIT;
            mem_req     <= 1'b0;
            outstanding <= BURST_O;
            mem_addr    <= mem_addr + BURST_A;
            issued      <= issued + BURST_I;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            outstanding <= outstanding - OUT_ONE;
            if (outstanding == OUT_ONE) state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          state    <= ST_IDLE;
          mem_addr <= BASE_A;
          issued   <= '0;
          if (!fs_rise) flush_pend <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed-random bench: memory responder and pixel-stream model kept in the bench.
module tb_vga_frame_reader;
  localparam int BURST = 16;

  logic        clk;
  logic        rst_n;
  logic        frame_sync;
  logic        data_req;
  logic [15:0] pix_data;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        underflow;
  logic [6:0]  fifo_level;

  vga_frame_reader #(
    .DATA_W(16), .ADDR_W(20), .FRAME_PIXELS(1024),
    .BASE_ADDR(0), .BURST_LEN(16), .FIFO_DEPTH(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_sync(frame_sync), .data_req(data_req),
    .pix_data(pix_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .underflow(underflow), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          avail, next_pix, beats_left, req_cyc, ack_dly, rv_pct, guard;
  logic [19:0] beat_addr;
  bit          stall, chk_on, exp_uf, fs_prev;
  logic [15:0] exp_pix;
  int          acc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: account for what the coming edge does, then check and drive the memory side.
  task automatic tick();
    bit acc, beat, rise;
    acc  = mem_req && mem_ack;
    beat = mem_rvalid;
    rise = frame_sync && !fs_prev;
    fs_prev = frame_sync;
    if (rise) exp_uf = 1'b0;
    if (data_req) begin
      if (avail > 0) begin
        exp_pix = 16'(next_pix);
        next_pix++;
        avail--;
      end else begin
        exp_pix = '0;
        exp_uf  = 1'b1;
      end
    end else begin
      exp_pix = '0;
    end
    if (beat) begin
      avail++;
      beats_left--;
      beat_addr++;
    end
    if (acc) begin
      acc_q.push_back(int'(mem_addr));
      beats_left = BURST;
      beat_addr  = mem_addr;
    end
    @(posedge clk);
    #1;
    if (chk_on) begin
      chk("pix_data", 32'(pix_data), 32'(exp_pix));
      chk("underflow", 32'(underflow), 32'(exp_uf));
      chk("fifo_level", 32'(fifo_level), avail);
    end
    if (mem_req) req_cyc++;
    else req_cyc = 0;
    mem_ack = mem_req && !stall && (req_cyc > ack_dly);
    if (beats_left > 0 && $urandom_range(99) < rv_pct) begin
      mem_rvalid = 1'b1;
      mem_rdata  = beat_addr[15:0];
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end
  endtask

  task automatic model_reset();
    avail = 0; next_pix = 0; beats_left = 0; req_cyc = 0; beat_addr = '0;
    exp_uf = 1'b0; exp_pix = '0; acc_q.delete();
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    fs_prev = frame_sync;
  endtask

  task automatic check_reset_outputs(input string sfx);
    chk({"rst_pix_", sfx}, 32'(pix_data), 0);
    chk({"rst_mem_req_", sfx}, 32'(mem_req), 0);
    chk({"rst_mem_addr_", sfx}, 32'(mem_addr), 0);
    chk({"rst_underflow_", sfx}, 32'(underflow), 0);
    chk({"rst_level_", sfx}, 32'(fifo_level), 0);
  endtask

  initial begin
    rst_n = 1'b0; frame_sync = 1'b0; data_req = 1'b0;
    stall = 1'b0; chk_on = 1'b1; ack_dly = 2; rv_pct = 100;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("init");
    rst_n = 1'b1;

    // Fill with no reader: exactly four bursts at 0,16,32,48.
    repeat (200) tick();
    chk("fill_nreq", acc_q.size(), 4);
    for (int i = 0; i < acc_q.size(); i++) chk("fill_addr", acc_q[i], i * BURST);
    chk("fill_level", 32'(fifo_level), 64);
    chk("fill_no_5th", 32'(mem_req), 0);
    chk("fill_addr_next", 32'(mem_addr), 64);

    // Stream the whole 1024-pixel frame with gappy requests.
    ack_dly = 1; rv_pct = 90; guard = 0;
    while (next_pix < 1024 && guard < 20000) begin
      data_req = ($urandom_range(99) < 60);
      tick();
      guard++;
    end
    chk("stream_done", next_pix, 1024);
    data_req = 1'b0;
    repeat (60) tick();
    chk("stream_underflow", 32'(underflow), 0);
    chk("eof_nreq", acc_q.size(), 64);
    for (int i = 0; i < acc_q.size(); i++) chk("stream_addr", acc_q[i], i * BURST);
    chk("eof_no_req", 32'(mem_req), 0);
    chk("eof_addr", 32'(mem_addr), 1024);

    // New frame, then frame_sync with 10 beats of a burst still outstanding.
    acc_q.delete(); next_pix = 0; rv_pct = 100;
    frame_sync = 1'b1;
    repeat (4) tick();
    frame_sync = 1'b0;
    guard = 0;
    while (beats_left != 10 && guard < 500) begin
      tick();
      guard++;
    end
    chk("flush_setup", beats_left, 10);
    chk_on = 1'b0; stall = 1'b1;
    frame_sync = 1'b1;
    repeat (4) tick();
    frame_sync = 1'b0;
    guard = 0;
    while (beats_left > 0 && guard < 100) begin
      tick();
      guard++;
    end
    repeat (5) tick();
    chk("flush_level", 32'(fifo_level), 0);
    chk("flush_req", 32'(mem_req), 1);
    chk("flush_addr", 32'(mem_addr), 0);
    chk("flush_nreq", acc_q.size(), 1);

    // Refill after the flush restarts at address 0.
    avail = 0; next_pix = 0; acc_q.delete(); chk_on = 1'b1; stall = 1'b0; rv_pct = 100;
    guard = 0;
    while ((acc_q.size() < 4 || beats_left > 0) && guard < 600) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    chk("refill_nreq", acc_q.size(), 4);
    for (int i = 0; i < acc_q.size(); i++) chk("refill_addr", acc_q[i], i * BURST);
    chk("refill_level", 32'(fifo_level), 64);

    // Stalled memory: the 65th back-to-back request underflows.
    stall = 1'b1; data_req = 1'b1;
    repeat (65) tick();
    chk("uf_pix", 32'(pix_data), 0);
    chk("uf_flag", 32'(underflow), 1);
    data_req = 1'b0;
    tick();
    chk("uf_sticky", 32'(underflow), 1);
    frame_sync = 1'b1;
    tick();
    chk("uf_cleared", 32'(underflow), 0);
    repeat (3) tick();
    frame_sync = 1'b0;
    tick();

    // Reset in the middle of a burst.
    chk_on = 1'b0; stall = 1'b0; rv_pct = 100;
    guard = 0;
    while (beats_left != 8 && guard < 300) begin
      tick();
      guard++;
    end
    chk("midrst_setup", beats_left, 8);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_on = 1'b1; ack_dly = 1; rv_pct = 80;
    repeat (300) begin
      data_req = ($urandom_range(99) < 50);
      tick();
    end
    chk("post_rst_req", 32'(acc_q.size() > 0), 1);
    if (acc_q.size() > 0) chk("post_rst_addr0", acc_q[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
